// File: rtl/sram_responder.sv
// Bridges a 32-bit CPU ROM/RAM port onto a 16-bit asynchronous SRAM.
// Each CPU access is split into a low and a high half-word SRAM cycle.
module sram_responder #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rom_addr,
  input  logic [31:0]       rom_din,
  input  logic [3:0]        mem_sel_be,
  input  logic              we,
  input  logic              rom_ce,
  input  logic              oe,
  output logic [15:0]       rom_data_a,
  output logic [15:0]       rom_data_b,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  typedef enum logic [2:0] {
    StIdle, StRdLo, StRdHi, StWrSetup, StWrPulse, StWrHold, StDone
  } state_e;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              half_q, half_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-2:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic              latch, smp_lo, smp_hi;

  // Byte-address bits outside the half-word window are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{rom_addr[31:ADDR_W+1], rom_addr[1:0]};

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    smp_lo  = 1'b0;
    smp_hi  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rom_ce) begin
          latch = 1'b1;
          cnt_d = 4'd0;
          if (we) begin
            if (|mem_sel_be[1:0]) begin
              state_d = StWrSetup;
              half_d  = 1'b0;
            end else if (|mem_sel_be[3:2]) begin
              state_d = StWrSetup;
              half_d  = 1'b1;
            end else begin
              state_d = StDone;
            end
          end else if (oe) begin
            state_d = StRdLo;
            half_d  = 1'b0;
          end
        end
      end
      StRdLo: begin
        if (cnt_q == LastCnt) begin
          smp_lo  = 1'b1;
          state_d = StRdHi;
          half_d  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRdHi: begin
        if (cnt_q == LastCnt) begin
          smp_hi  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = 4'd0;
      end
      StWrPulse: begin
        if (cnt_q == LastCnt) state_d = StWrHold;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      StWrHold: begin
        if (!half_q && (|be_q[3:2])) begin
          state_d = StWrSetup;
          half_d  = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        half_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      half_q     <= 1'b0;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      be_q       <= 4'd0;
      rom_data_a <= 16'd0;
      rom_data_b <= 16'd0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q <= rom_addr[ADDR_W:2];
        data_q <= rom_din;
        be_q   <= mem_sel_be;
      end
      if (smp_lo) rom_data_b <= sram_dq_in;
      if (smp_hi) rom_data_a <= sram_dq_in;
    end
  end

  // SRAM strobes are decoded straight from the state so reset drops them at once.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state_q)
      StRdLo, StRdHi: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_ub_n = 1'b0;
      end
      StWrSetup, StWrPulse, StWrHold: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_we_n  = (state_q == StWrPulse) ? 1'b0 : 1'b1;
        sram_lb_n  = half_q ? ~be_q[2] : ~be_q[0];
        sram_ub_n  = half_q ? ~be_q[3] : ~be_q[1];
      end
      default: ;
    endcase
  end

  assign sram_addr   = {addr_q, half_q};
  assign sram_dq_out = half_q ? data_q[31:16] : data_q[15:0];
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, the external SRAM half-word address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, the strobe cycles per half-word access (legal range 1..15).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port rom_addr  in  32  CPU byte address; bits [ADDR_W:2] used, others ignored.
REQ-006 SHALL have port rom_din  in  32  CPU write data.
REQ-007 SHALL have port mem_sel_be  in  4  write byte enables; bit i enables byte i.
REQ-008 SHALL have ports we / rom_ce / oe  in  1 each  CPU write, chip-enable and read strobes, active-high.
REQ-009 SHALL have port rom_data_a  out  16  read data bits [31:16], registered.
REQ-010 SHALL have port rom_data_b  out  16  read data bits [15:0], registered.
REQ-011 SHALL have ports busy / done  out  1 each  access in progress / one-cycle completion pulse.
REQ-012 SHALL have port sram_addr  out  ADDR_W  half-word address.
REQ-013 SHALL have ports sram_dq_out  out  16, sram_dq_oe  out  1, sram_dq_in  in  16  split bidirectional data bus.
REQ-014 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes.

Function
REQ-015 SHALL use the states IDLE, RD_LO, RD_HI, WR_SETUP, WR_PULSE, WR_HOLD and DONE; the write states carry a half bit (LO/HI).
REQ-016 In IDLE with rom_ce=1, SHALL latch the address, data and byte enables and go to WR_SETUP(LO) if we=1, else RD_LO if oe=1; with rom_ce=1 and we=oe=0 it SHALL stay in IDLE.
REQ-017 SHALL give write precedence when we and oe are both 1.
REQ-018 SHALL ignore rom_ce while not in IDLE; the CPU stalls on busy.
REQ-019 SHALL set sram_addr = {latched rom_addr[ADDR_W:2], half}, with LO=0 and HI=1; higher address bits wrap silently.
REQ-020 RD_LO and RD_HI SHALL each last WAIT_CYCLES cycles with sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_lb_n=sram_ub_n=0 and sram_dq_oe=0.
REQ-021 On the last cycle of RD_LO, SHALL register sram_dq_in into rom_data_b; on the last cycle of RD_HI, into rom_data_a.
REQ-022 WR_SETUP SHALL last 1 cycle with sram_ce_n=0, sram_we_n=1, sram_dq_oe=1 and sram_dq_out = the selected half of latched data.
REQ-023 WR_PULSE SHALL last WAIT_CYCLES cycles, as WR_SETUP but with sram_we_n=0.
REQ-024 WR_HOLD SHALL last 1 cycle, as WR_SETUP; sram_dq_oe SHALL be 1 only in write states.
REQ-025 During the LO write half, sram_lb_n=~be[0] and sram_ub_n=~be[1]; during the HI write half, ~be[2] and ~be[3].
REQ-026 SHALL skip a write half entirely (no strobes) when its two enables are 00; if all four are 0, SHALL go straight to DONE.
REQ-027 Outside the access states, SHALL hold sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n and sram_ub_n at 1, and sram_dq_oe at 0.
REQ-028 busy SHALL be 1 in every state except IDLE and DONE; done SHALL be 1 only in DONE, which lasts 1 cycle then returns to IDLE.
REQ-029 A new request SHALL be accepted in the IDLE cycle right after DONE, giving back-to-back accesses.
REQ-030 rom_data_a and rom_data_b SHALL hold their value across writes and idle cycles, changing only on read samples.
REQ-031 Latency from the accepting edge to done=1 SHALL be 2*WAIT_CYCLES+1 cycles for a read and 2*(WAIT_CYCLES+2)+1 for a full write.

Reset
REQ-032 With rst=1 at an edge, SHALL enter IDLE and set busy=0, done=0, rom_data_a=rom_data_b=0, all strobes=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-033 rst SHALL abort an in-flight access immediately with no further strobes; rst SHALL win over a simultaneous rom_ce.

Verification
REQ-034 WAIT_CYCLES=1, SRAM model holds 0x1234 at half-address 0x010 and 0xABCD at 0x011; read rom_addr=0x20 -> done 3 cycles after accept, rom_data_a=0xABCD, rom_data_b=0x1234.
REQ-035 Write rom_addr=0x20, rom_din=0xDEADBEEF, be=1111 -> two we_n pulses: BEEF to 0x010, then DEAD to 0x011; done at cycle 7; readback matches.
REQ-036 Write with be=0100 -> only the HI half is strobed, with lb_n=0 and ub_n=1, done at cycle 4; be=0000 -> no strobes, done at cycle 1.
REQ-037 Extra rom_ce pulses while busy=1 -> ignored and SRAM untouched; a request in the cycle after done -> accepted.
REQ-038 rst asserted during WR_PULSE(LO) -> next cycle strobes high, busy=0, rom_data_a/b=0, and the HI half is never written.
REQ-039 WAIT_CYCLES=3 read -> oe_n low for 3 cycles per half, done 7 cycles after accept.
